// File: rtl/neuron_argmax_collector.sv
// -----------------------------------------------------------------------------
// neuron_argmax_collector
//
// Consumer end of the output neuron layer. It waits for every neuron to
// report done and, on the rising edge of that "all done" condition, takes a
// snapshot of all neuron scores. It then walks the snapshot one score per
// cycle looking for the largest signed value, and publishes the winning class
// index together with its score.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset
//   IN_SCORES    concatenated neuron scores; neuron k at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   NEURON_DONE  per-neuron done levels (held high while a result is held)
//   CLASS        index of the winning neuron
//   MAX_SCORE    score of the winning neuron, bit-exact copy of the input
//   valid        CLASS/MAX_SCORE hold a completed result
//   busy         a scan is in progress
//   overrun      sticky: a new all-done edge arrived during a scan
// -----------------------------------------------------------------------------
module neuron_argmax_collector #(
    parameter int NUM_NEURONS  = 10,
    parameter int OUTPUT_WIDTH = 26,
    parameter int CLASS_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
    input  logic [NUM_NEURONS-1:0]              NEURON_DONE,
    output logic [CLASS_WIDTH-1:0]              CLASS,
    output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
    output logic                                valid,
    output logic                                busy,
    output logic                                overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_NEURONS - 1);

    state_t state;

    logic all_done;
    logic all_done_q;
    logic start;

    logic signed [OUTPUT_WIDTH-1:0] in_score  [NUM_NEURONS];
    logic signed [OUTPUT_WIDTH-1:0] score_buf [NUM_NEURONS];

    logic signed [OUTPUT_WIDTH-1:0] best_score;
    logic [CLASS_WIDTH-1:0]         best_idx;
    logic [CLASS_WIDTH-1:0]         idx;

    logic signed [OUTPUT_WIDTH-1:0] cand_score;
    logic signed [OUTPUT_WIDTH-1:0] next_best_score;
    logic [CLASS_WIDTH-1:0]         next_best_idx;

    // Split the flat input bus into one signed score per neuron.
    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_unpack
        assign in_score[k] = IN_SCORES[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    end

    // Only the rising edge of "all done" starts a scan, so a done level held
    // high across the result never retriggers.
    assign all_done = &NEURON_DONE;
    assign start    = all_done & ~all_done_q;

    // Running compare for the current scan position. Strict greater-than keeps
    // the lower index on ties.
    always_comb begin
        cand_score      = score_buf[idx];
        next_best_score = best_score;
        next_best_idx   = best_idx;
        if (cand_score > best_score) begin
            next_best_score = cand_score;
            next_best_idx   = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            all_done_q <= 1'b0;
            CLASS      <= '0;
            MAX_SCORE  <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            best_score <= '0;
            best_idx   <= '0;
            idx        <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                score_buf[k] <= '0;
            end
        end else begin
            all_done_q <= all_done;

            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        // Snapshot: later changes on IN_SCORES cannot disturb
                        // this result.
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            score_buf[k] <= in_score[k];
                        end
                        best_score <= in_score[0];
                        best_idx   <= '0;
                        idx        <= CLASS_WIDTH'(1);
                        valid      <= 1'b0;
                        if (NUM_NEURONS == 1) begin
                            // Single neuron: nothing to compare, publish now.
                            CLASS     <= '0;
                            MAX_SCORE <= in_score[0];
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            busy  <= 1'b1;
                            state <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    // A fresh all-done edge mid-scan is dropped but remembered.
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    best_score <= next_best_score;
                    best_idx   <= next_best_idx;
                    idx        <= idx + CLASS_WIDTH'(1);
                    if (idx == LAST_IDX) begin
                        CLASS     <= next_best_idx;
                        MAX_SCORE <= next_best_score;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HOLD;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
